// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size encodings, byte-lane masks
// and the bus FSM state type.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SIZE_B:  mask = MASK_B;
      SIZE_H:  mask = MASK_H;
      SIZE_W:  mask = MASK_W;
      default: mask = MASK_D;
    endcase
    return mask;
  endfunction

  // Natural alignment: the low address bits below the access size must be zero.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      SIZE_W:  mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_stage_if;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    output dmem_wstrb_o,
    input  dmem_gnt_i,
    input  dmem_rvalid_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    input  dmem_wstrb_o,
    output dmem_gnt_i,
    output dmem_rvalid_i,
    output dmem_rdata_i
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the 64-bit data bus: store data/strobe placement and
// load data extraction with sign or zero extension.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] sdata,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;

  assign shamt   = {offset, 3'b000};
  assign wdata   = sdata << shamt;
  assign wstrb   = size_mask(funct3[1:0]) << offset;
  assign shifted = rdata >> shamt;

  // funct3[2] selects the unsigned load variants.
  always_comb begin
    load_data = shifted;
    case (funct3[1:0])
      SIZE_B:  load_data = funct3[2] ? {56'b0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = funct3[2] ? {48'b0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W:  load_data = funct3[2] ? {32'b0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data bus for loads/stores, stalls upstream
// until the access completes, and registers the write-back bundle.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] sdata_i,
  input  logic [63:0] addr_i,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] pc_i,
  input  logic        exit_i,
  mem_stage_if.master dmem,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wdata_o,
  output logic [63:0] pc_o,
  output logic        exit_o,
  output logic        misaligned_o,
  output logic        mem_not_ready_o
);

  state_t      state, state_next;
  logic        access;
  logic        misaligned;
  logic        aligned_access;
  logic        complete;
  logic        req;
  logic [63:0] load_data;

  assign access         = load_i | store_i;
  assign misaligned     = access & is_misaligned(funct3_i[1:0], addr_i[2:0]);
  assign aligned_access = access & ~misaligned;

  lsu_align u_lsu_align (
    .funct3    (funct3_i),
    .offset    (addr_i[2:0]),
    .sdata     (sdata_i),
    .rdata     (dmem.dmem_rdata_i),
    .wdata     (dmem.dmem_wdata_o),
    .wstrb     (dmem.dmem_wstrb_o),
    .load_data (load_data)
  );

  // Address/data/strobe follow the inputs, which upstream holds while stalled.
  assign dmem.dmem_addr_o = {addr_i[63:3], 3'b000};
  assign dmem.dmem_we_o   = store_i;
  assign dmem.dmem_req_o  = req & ~reset;
  assign mem_not_ready_o  = aligned_access & ~complete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stores finish on grant; loads finish only on rvalid seen in WAIT.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_access) begin
          req = 1'b1;
          if (dmem.dmem_gnt_i) begin
            if (store_i) complete   = 1'b1;
            else         state_next = WAIT;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem.dmem_gnt_i) begin
          if (store_i) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid_i) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A stall cycle inserts a bubble; rd/pc/wdata keep their old values then.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wen_o        <= 1'b0;
      rd_o         <= 5'd0;
      wdata_o      <= 64'd0;
      pc_o         <= 64'd0;
      exit_o       <= 1'b0;
      misaligned_o <= 1'b0;
    end else if (mem_not_ready_o) begin
      wen_o        <= 1'b0;
      exit_o       <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      wen_o        <= wen_i & ~store_i & ~misaligned;
      rd_o         <= rd_i;
      wdata_o      <= load_i ? load_data : addr_i;
      pc_o         <= pc_i;
      exit_o       <= exit_i;
      misaligned_o <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: hand-computed expectations for loads, stores,
// misaligned accesses, pass-through and reset in the middle of a load.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_i, store_i, wen_i, exit_i;
  logic [2:0]  funct3_i;
  logic [63:0] sdata_i, addr_i, pc_i;
  logic [4:0]  rd_i;
  logic        wen_o, exit_o, misaligned_o, mem_not_ready_o;
  logic [4:0]  rd_o;
  logic [63:0] wdata_o, pc_o;

  int errors = 0;
  int checks = 0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clock           (clock),
    .reset           (reset),
    .load_i          (load_i),
    .store_i         (store_i),
    .funct3_i        (funct3_i),
    .sdata_i         (sdata_i),
    .addr_i          (addr_i),
    .wen_i           (wen_i),
    .rd_i            (rd_i),
    .pc_i            (pc_i),
    .exit_i          (exit_i),
    .dmem            (dmem.master),
    .wen_o           (wen_o),
    .rd_o            (rd_o),
    .wdata_o         (wdata_o),
    .pc_o            (pc_o),
    .exit_o          (exit_o),
    .misaligned_o    (misaligned_o),
    .mem_not_ready_o (mem_not_ready_o)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] sdata, input logic [63:0] addr,
                               input logic wen, input logic [4:0] rd,
                               input logic [63:0] pc, input logic ex);
    load_i   = ld;
    store_i  = st;
    funct3_i = f3;
    sdata_i  = sdata;
    addr_i   = addr;
    wen_i    = wen;
    rd_i     = rd;
    pc_i     = pc;
    exit_i   = ex;
  endtask

  task automatic setBus(input logic gnt, input logic rvalid, input logic [63:0] rdata);
    dmem.dmem_gnt_i    = gnt;
    dmem.dmem_rvalid_i = rvalid;
    dmem.dmem_rdata_i  = rdata;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    setBus(0, 0, 64'd0);
    tick();
    tick();
    checkOutput("rst_wen", wen_o, 1'b0);
    checkOutput("rst_wdata", wdata_o, 64'd0);
    checkOutput("rst_req", dmem.dmem_req_o, 1'b0);
    reset = 1'b0;

    $display("[TB] ADD pass-through");
    applyStimulus(0, 0, 3'd0, 64'd0, 64'h1234, 1, 5'd5, 64'h100, 1);
    #1;
    checkOutput("add_req", dmem.dmem_req_o, 1'b0);
    checkOutput("add_stall", mem_not_ready_o, 1'b0);
    tick();
    checkOutput("add_wdata", wdata_o, 64'h1234);
    checkOutput("add_rd", rd_o, 5'd5);
    checkOutput("add_wen", wen_o, 1'b1);
    checkOutput("add_pc", pc_o, 64'h100);
    checkOutput("add_exit", exit_o, 1'b1);

    $display("[TB] LB gnt then rvalid");
    applyStimulus(1, 0, 3'd0, 64'd0, 64'h1003, 1, 5'd7, 64'h104, 0);
    setBus(1, 0, 64'd0);
    #1;
    checkOutput("lb_req", dmem.dmem_req_o, 1'b1);
    checkOutput("lb_addr", dmem.dmem_addr_o, 64'h1000);
    checkOutput("lb_we", dmem.dmem_we_o, 1'b0);
    checkOutput("lb_stall0", mem_not_ready_o, 1'b1);
    tick();
    checkOutput("lb_bubble_wen", wen_o, 1'b0);
    setBus(0, 1, 64'h0000_0000_8000_0000);
    #1;
    checkOutput("lb_wait_req", dmem.dmem_req_o, 1'b0);
    checkOutput("lb_stall1", mem_not_ready_o, 1'b0);
    tick();
    checkOutput("lb_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_wen", wen_o, 1'b1);
    checkOutput("lb_rd", rd_o, 5'd7);
    applyStimulus(0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    setBus(0, 0, 64'd0);
    tick();

    $display("[TB] SH with delayed grant");
    applyStimulus(0, 1, 3'd1, 64'hBEEF, 64'h2006, 1, 5'd9, 64'h108, 1);
    for (int i = 0; i < 4; i++) begin
      setBus(i == 3, 0, 64'd0);
      #1;
      checkOutput($sformatf("sh_req%0d", i), dmem.dmem_req_o, 1'b1);
      checkOutput($sformatf("sh_wstrb%0d", i), dmem.dmem_wstrb_o, 8'hC0);
      checkOutput($sformatf("sh_wdata%0d", i), dmem.dmem_wdata_o, 64'hBEEF_0000_0000_0000);
      checkOutput($sformatf("sh_we%0d", i), dmem.dmem_we_o, 1'b1);
      checkOutput($sformatf("sh_stall%0d", i), mem_not_ready_o, i != 3);
      tick();
      if (i < 3) checkOutput($sformatf("sh_bubble_exit%0d", i), exit_o, 1'b0);
    end
    checkOutput("sh_wen", wen_o, 1'b0);
    checkOutput("sh_pc", pc_o, 64'h108);
    checkOutput("sh_exit", exit_o, 1'b1);

    $display("[TB] SB immediate grant");
    applyStimulus(0, 1, 3'd0, 64'hAA, 64'h3005, 0, 5'd0, 64'h10C, 0);
    setBus(1, 0, 64'd0);
    #1;
    checkOutput("sb_wstrb", dmem.dmem_wstrb_o, 8'h20);
    checkOutput("sb_wdata", dmem.dmem_wdata_o, 64'h0000_AA00_0000_0000);
    checkOutput("sb_stall", mem_not_ready_o, 1'b0);
    tick();
    checkOutput("sb_pc", pc_o, 64'h10C);

    $display("[TB] LW misaligned");
    applyStimulus(1, 0, 3'd2, 64'd0, 64'h1002, 1, 5'd3, 64'h110, 0);
    setBus(0, 0, 64'd0);
    #1;
    checkOutput("lw_mis_req", dmem.dmem_req_o, 1'b0);
    checkOutput("lw_mis_stall", mem_not_ready_o, 1'b0);
    tick();
    checkOutput("lw_mis_flag", misaligned_o, 1'b1);
    checkOutput("lw_mis_wen", wen_o, 1'b0);
    applyStimulus(0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    tick();
    checkOutput("lw_mis_pulse", misaligned_o, 1'b0);

    $display("[TB] LWU with rvalid two cycles after grant");
    applyStimulus(1, 0, 3'd6, 64'd0, 64'h8, 1, 5'd11, 64'h114, 0);
    setBus(1, 0, 64'h1111_2222_3333_4444);
    tick();
    setBus(0, 0, 64'h1111_2222_3333_4444);
    #1;
    checkOutput("lwu_wait_stall", mem_not_ready_o, 1'b1);
    checkOutput("lwu_wait_req", dmem.dmem_req_o, 1'b0);
    tick();
    setBus(0, 1, 64'hFFFF_FFFF_8000_0001);
    tick();
    checkOutput("lwu_wdata", wdata_o, 64'h0000_0000_8000_0001);
    checkOutput("lwu_wen", wen_o, 1'b1);
    checkOutput("lwu_rd", rd_o, 5'd11);
    applyStimulus(0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    setBus(0, 0, 64'd0);
    tick();

    $display("[TB] Reset while waiting for rvalid");
    applyStimulus(1, 0, 3'd3, 64'd0, 64'h10, 1, 5'd12, 64'h118, 1);
    setBus(1, 0, 64'd0);
    tick();
    setBus(0, 0, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstw_req", dmem.dmem_req_o, 1'b0);
    checkOutput("rstw_state", 64'(dut.state), 64'(IDLE));
    checkOutput("rstw_pc", pc_o, 64'd0);
    checkOutput("rstw_rd", rd_o, 5'd0);
    checkOutput("rstw_wdata", wdata_o, 64'd0);
    checkOutput("rstw_exit", exit_o, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0, 0);
    setBus(0, 1, 64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    checkOutput("late_rvalid_wen", wen_o, 1'b0);
    checkOutput("late_rvalid_wdata", wdata_o, 64'd0);
    applyStimulus(1, 0, 3'd3, 64'd0, 64'h20, 1, 5'd13, 64'h11C, 0);
    #1;
    checkOutput("idle_rvalid_req", dmem.dmem_req_o, 1'b1);
    checkOutput("idle_rvalid_stall", mem_not_ready_o, 1'b1);
    tick();
    setBus(1, 0, 64'd0);
    tick();
    setBus(0, 1, 64'h0123_4567_89AB_CDEF);
    tick();
    checkOutput("ld_after_rst_wdata", wdata_o, 64'h0123_4567_89AB_CDEF);
    checkOutput("ld_after_rst_wen", wen_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
